register_file_unit: RTL and testbench
=====================================

Name: register_file_unit

Overview:
- Architectural integer register file: the receiving end of the write-back interface. Commits `register_op`/`register_data` produced by the write-back stage into x1..x31.
- Serves two combinational read ports to the decode stage.
- Tracks in-flight destination registers with a per-register pending-write scoreboard and raises a stall for read-after-write hazards.
- Sits between decode (read/issue side) and write-back (commit side).

Parameters:
- NUM_REGS, 32, number of architectural registers; index width is $clog2(NUM_REGS).
- PEND_W, 2, width of each pending-write counter; max in-flight writes per register = 2**PEND_W-1.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset; sampled on posedge clock.
- register_op  in  reg_file_op_t  write-back command (NO_REG_DATA / WRITE_REG_DATA).
- register_data  in  word  write-back data.
- wb_rd  in  5  destination index of the write-back commit.
- rs1_addr  in  5  read port 1 index.
- rs2_addr  in  5  read port 2 index.
- rs1_data  out  word  read port 1 data (combinational).
- rs2_data  out  word  read port 2 data (combinational).
- issue_valid  in  1  decode is issuing an instruction this cycle.
- issue_writes  in  1  issued instruction will write a register.
- issue_rd  in  5  destination of the issued instruction.
- issue_ready  out  1  issue accepted this cycle (no hazard, no counter saturation).
- hazard_stall  out  1  rs1 or rs2 has a pending write.

Behaviour:
- Reset (reset_n=0 at posedge): all registers cleared to 0; all pending counters cleared to 0. No commit or issue takes effect in that cycle. Outputs are combinational from state, so after reset rs*_data=0, hazard_stall=0, issue_ready=issue_valid-independent 1.
- x0: reads always return 0. Writes to x0 are discarded. Issues with issue_rd=0 never increment a counter. A commit with wb_rd=0 never decrements a counter.
- Write: on posedge, if reset_n=1, register_op==WRITE_REG_DATA and wb_rd!=0, then regs[wb_rd] <= register_data. NO_REG_DATA and any undefined encoding perform no write.
- Read bypass: if a write to rs is active this cycle (WRITE_REG_DATA, wb_rd==rs, rs!=0), rsN_data = register_data. Otherwise rsN_data = regs[rs]. Read latency is 0 cycles, so a value written in cycle N is visible the same cycle via bypass and from storage at N+1.
- Scoreboard: pend[r] is a PEND_W-bit counter.
  - inc = issue_valid & issue_ready & issue_writes & issue_rd!=0.
  - dec = register_op==WRITE_REG_DATA & wb_rd!=0.
  - If inc and dec target the same r in the same cycle, pend[r] is unchanged.
  - Otherwise inc does +1 and dec does -1 on its own target.
  - dec when pend[wb_rd]==0 (commit of a write that was never issued) leaves the counter at 0; no underflow.
- Hazard:
  - rsN_busy = rsN!=0 & pend[rsN]!=0 & !(dec & wb_rd==rsN & pend[rsN]==1). The last write resolves via bypass in the same cycle.
  - hazard_stall = rs1_busy | rs2_busy.
  - rs addresses are assumed used. Decode drives rs=0 for unused operands.
- issue_ready = !hazard_stall & !(issue_writes & issue_rd!=0 & pend[issue_rd]==max & !(dec & wb_rd==issue_rd)). Counter saturation blocks issue; it never wraps.
- Reset mid-operation discards all pending state. In-flight commits arriving after reset still write data; their counter decrements clamp at 0.

Decomposition:
- Shared package (params.sv): word, reg_file_op_t (NO_REG_DATA, WRITE_REG_DATA), REG_ADDR_W=5 constant, and a new reg_addr_t typedef.
- One natural sub-module: `pending_scoreboard`. It holds the counters and produces the busy, inc/dec and saturation logic. The storage and bypass stay in the top module.

Test Plan:
- Reset then read rs1=5, rs2=31 -> both 0. Hold reset_n=0 while driving WRITE_REG_DATA wb_rd=5 data=0xDEAD_BEEF -> regs[5] stays 0 after release.
- Commit WRITE_REG_DATA wb_rd=0 data=0x1234 -> rs1_addr=0 returns 0 that cycle and the next.
- Commit wb_rd=7 data=0xCAFE_F00D with rs1=rs2=7 in the same cycle -> both outputs 0xCAFE_F00D (bypass). Next cycle they are unchanged from storage.
- Issue rd=3, then next cycle read rs1=3 -> hazard_stall=1 and issue_ready=0. Commit wb_rd=3 value 0x11 -> same cycle hazard_stall=0 and rs1_data=0x11.
- Issue rd=9 three times with no commits -> pend[9]=3. A fourth issue to rd=9 gives issue_ready=0. The fourth issue with a simultaneous commit to 9 gives issue_ready=1 and pend stays 3.
- Simultaneous issue rd=4 and commit wb_rd=4 with pend[4]=1 -> pend[4] stays 1. Commit to wb_rd=12 with pend[12]=0 -> pend stays 0 and data is written.

Source files
------------

// File: rtl/register_file_unit_pkg.sv
// Shared types for the integer register file: data word, write-back command
// encoding and register index.
package register_file_unit_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [31:0]           word;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Encodings 2 and 3 are undefined and treated as "no write".
    typedef enum logic [1:0] {
        NO_REG_DATA    = 2'd0,
        WRITE_REG_DATA = 2'd1
    } reg_file_op_t;

endpackage

// File: rtl/register_file_unit_if.sv
// Decode/write-back facing bus of the register file: commit, two read ports
// and the issue handshake.
interface register_file_unit_if;
    import register_file_unit_pkg::*;

    reg_file_op_t register_op;
    word          register_data;
    reg_addr_t    wb_rd;
    reg_addr_t    rs1_addr;
    reg_addr_t    rs2_addr;
    word          rs1_data;
    word          rs2_data;
    logic         issue_valid;
    logic         issue_writes;
    reg_addr_t    issue_rd;
    logic         issue_ready;
    logic         hazard_stall;

    modport master (
        output register_op, register_data, wb_rd, rs1_addr, rs2_addr,
               issue_valid, issue_writes, issue_rd,
        input  rs1_data, rs2_data, issue_ready, hazard_stall
    );

    modport slave (
        input  register_op, register_data, wb_rd, rs1_addr, rs2_addr,
               issue_valid, issue_writes, issue_rd,
        output rs1_data, rs2_data, issue_ready, hazard_stall
    );

endinterface

// File: rtl/register_file_unit_pending_scoreboard.sv
// Per-register in-flight write counters; produces the RAW stall and the
// issue-accept decision (hazard or counter saturation blocks issue).
module pending_scoreboard
    import register_file_unit_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int PEND_W   = 2
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      issue_valid,
    input  logic      issue_writes,
    input  reg_addr_t issue_rd,
    input  logic      commit_wr,
    input  reg_addr_t wb_rd,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    output logic      hazard_stall,
    output logic      issue_ready
);

    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] pend_q [NUM_REGS];
    logic [PEND_W-1:0] pend_d [NUM_REGS];

    logic dec;
    logic inc;
    logic rs1_busy;
    logic rs2_busy;
    logic sat_block;

    always_comb begin
        dec = commit_wr && (wb_rd != '0);

        // A register whose last outstanding write commits this cycle is served by bypass.
        rs1_busy = (rs1_addr != '0) && (pend_q[rs1_addr] != '0)
                   && !(dec && (wb_rd == rs1_addr) && (pend_q[rs1_addr] == PEND_ONE));
        rs2_busy = (rs2_addr != '0) && (pend_q[rs2_addr] != '0)
                   && !(dec && (wb_rd == rs2_addr) && (pend_q[rs2_addr] == PEND_ONE));
        hazard_stall = rs1_busy || rs2_busy;

        sat_block = issue_writes && (issue_rd != '0) && (pend_q[issue_rd] == PEND_MAX)
                    && !(dec && (wb_rd == issue_rd));
        issue_ready = !hazard_stall && !sat_block;

        inc = issue_valid && issue_ready && issue_writes && (issue_rd != '0);
    end

    always_comb begin
        pend_d = pend_q;
        if (!(inc && dec && (issue_rd == wb_rd))) begin
            if (inc) begin
                pend_d[issue_rd] = pend_q[issue_rd] + PEND_ONE;
            end
            // Commits of never-issued writes clamp at zero.
            if (dec && (pend_q[wb_rd] != '0)) begin
                pend_d[wb_rd] = pend_q[wb_rd] - PEND_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/register_file_unit.sv
// Architectural register file x0..x31: write-back commit, two bypassed
// combinational read ports and the pending-write scoreboard.
module register_file_unit
    import register_file_unit_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int PEND_W   = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    register_file_unit_if.slave rf
);

    word  regs_q [NUM_REGS];
    word  regs_d [NUM_REGS];
    logic commit_wr;

    assign commit_wr = (rf.register_op == WRITE_REG_DATA);

    always_comb begin
        regs_d = regs_q;
        if (commit_wr && (rf.wb_rd != '0)) begin
            regs_d[rf.wb_rd] = rf.register_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Same-cycle commit to the addressed register is forwarded ahead of storage.
    always_comb begin
        if (rf.rs1_addr == '0) begin
            rf.rs1_data = '0;
        end else if (commit_wr && (rf.wb_rd == rf.rs1_addr)) begin
            rf.rs1_data = rf.register_data;
        end else begin
            rf.rs1_data = regs_q[rf.rs1_addr];
        end

        if (rf.rs2_addr == '0) begin
            rf.rs2_data = '0;
        end else if (commit_wr && (rf.wb_rd == rf.rs2_addr)) begin
            rf.rs2_data = rf.register_data;
        end else begin
            rf.rs2_data = regs_q[rf.rs2_addr];
        end
    end

    pending_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .PEND_W   (PEND_W)
    ) u_scoreboard (
        .clock        (clock),
        .reset_n      (reset_n),
        .issue_valid  (rf.issue_valid),
        .issue_writes (rf.issue_writes),
        .issue_rd     (rf.issue_rd),
        .commit_wr    (commit_wr),
        .wb_rd        (rf.wb_rd),
        .rs1_addr     (rf.rs1_addr),
        .rs2_addr     (rf.rs2_addr),
        .hazard_stall (rf.hazard_stall),
        .issue_ready  (rf.issue_ready)
    );

endmodule

// File: tb/tb_register_file_unit.sv
// Bench for register_file_unit: directed scenarios followed by random traffic,
// every cycle compared against a reference model of registers and in-flight counts.
module tb_register_file_unit;
    import register_file_unit_pkg::*;

    localparam int MAX_PEND = 3;

    logic clock;
    logic reset_n;
    register_file_unit_if rf();

    register_file_unit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .rf      (rf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Reference state: architectural values and number of writes in flight.
    logic [31:0] m_regs [32];
    int          m_pend [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_commit();
        return (rf.register_op == WRITE_REG_DATA) && (rf.wb_rd != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input int rs);
        if (rs == 0) return 32'd0;
        if (m_commit() && int'(rf.wb_rd) == rs) return rf.register_data;
        return m_regs[rs];
    endfunction

    function automatic bit m_busy(input int rs);
        if (rs == 0 || m_pend[rs] == 0) return 1'b0;
        // last outstanding write landing now is forwarded, so no wait
        if (m_commit() && int'(rf.wb_rd) == rs && m_pend[rs] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        return m_busy(int'(rf.rs1_addr)) || m_busy(int'(rf.rs2_addr));
    endfunction

    function automatic bit m_ready();
        int  rd;
        bit  full;
        rd   = int'(rf.issue_rd);
        full = rf.issue_writes && rd != 0 && m_pend[rd] == MAX_PEND
               && !(m_commit() && int'(rf.wb_rd) == rd);
        return !m_stall() && !full;
    endfunction

    task automatic set_idle();
        rf.register_op   = NO_REG_DATA;
        rf.register_data = 32'd0;
        rf.wb_rd         = 5'd0;
        rf.rs1_addr      = 5'd0;
        rf.rs2_addr      = 5'd0;
        rf.issue_valid   = 1'b0;
        rf.issue_writes  = 1'b0;
        rf.issue_rd      = 5'd0;
    endtask

    // Inputs are already driven (after a negedge): compare, clock, update model.
    task automatic step();
        bit inc;
        bit dec;
        int ird;
        int wrd;
        #1;
        check("rs1_data", rf.rs1_data, m_read(int'(rf.rs1_addr)));
        check("rs2_data", rf.rs2_data, m_read(int'(rf.rs2_addr)));
        check("hazard_stall", 32'(rf.hazard_stall), 32'(m_stall()));
        check("issue_ready", 32'(rf.issue_ready), 32'(m_ready()));
        ird = int'(rf.issue_rd);
        wrd = int'(rf.wb_rd);
        inc = rf.issue_valid && m_ready() && rf.issue_writes && ird != 0;
        dec = m_commit();
        @(posedge clock);
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_pend[i] = 0;
            end
        end else begin
            if (dec) m_regs[wrd] = rf.register_data;
            if (inc) m_pend[ird] = m_pend[ird] + 1;
            if (dec && m_pend[wrd] > 0) m_pend[wrd] = m_pend[wrd] - 1;
        end
        @(negedge clock);
    endtask

    task automatic do_issue(input logic [4:0] rd);
        set_idle();
        rf.issue_valid  = 1'b1;
        rf.issue_writes = 1'b1;
        rf.issue_rd     = rd;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [31:0] data);
        set_idle();
        rf.register_op   = WRITE_REG_DATA;
        rf.wb_rd         = rd;
        rf.register_data = data;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'hx;
            m_pend[i] = 0;
        end
        set_idle();
        reset_n = 1'b0;
        @(negedge clock);

        // Reset dominates a concurrent commit
        do_commit(5'd5, 32'hDEAD_BEEF);
        @(posedge clock);
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 0;
        end
        @(negedge clock);
        step();
        reset_n = 1'b1;
        set_idle();
        rf.rs1_addr = 5'd5;
        rf.rs2_addr = 5'd31;
        #1;
        check("reset_rs1", rf.rs1_data, 32'd0);
        check("reset_rs2", rf.rs2_data, 32'd0);
        check("reset_stall", 32'(rf.hazard_stall), 32'd0);
        check("reset_ready", 32'(rf.issue_ready), 32'd1);
        step();

        // x0 is hard-wired
        do_commit(5'd0, 32'h0000_1234);
        #1;
        check("x0_same", rf.rs1_data, 32'd0);
        step();
        set_idle();
        #1;
        check("x0_next", rf.rs1_data, 32'd0);
        step();

        // Bypass then storage
        do_commit(5'd7, 32'hCAFE_F00D);
        rf.rs1_addr = 5'd7;
        rf.rs2_addr = 5'd7;
        #1;
        check("byp_rs1", rf.rs1_data, 32'hCAFE_F00D);
        check("byp_rs2", rf.rs2_data, 32'hCAFE_F00D);
        step();
        set_idle();
        rf.rs1_addr = 5'd7;
        rf.rs2_addr = 5'd7;
        #1;
        check("stor_rs1", rf.rs1_data, 32'hCAFE_F00D);
        check("stor_rs2", rf.rs2_data, 32'hCAFE_F00D);
        step();

        // RAW hazard and its resolution by a same-cycle commit
        do_issue(5'd3);
        step();
        set_idle();
        rf.rs1_addr    = 5'd3;
        rf.issue_valid = 1'b1;
        #1;
        check("raw_stall", 32'(rf.hazard_stall), 32'd1);
        check("raw_ready", 32'(rf.issue_ready), 32'd0);
        step();
        do_commit(5'd3, 32'h11);
        rf.rs1_addr = 5'd3;
        #1;
        check("raw_clear", 32'(rf.hazard_stall), 32'd0);
        check("raw_byp", rf.rs1_data, 32'h11);
        step();

        // Counter saturation on x9
        for (int k = 0; k < 3; k++) begin
            do_issue(5'd9);
            step();
        end
        do_issue(5'd9);
        #1;
        check("sat_block", 32'(rf.issue_ready), 32'd0);
        step();
        do_issue(5'd9);
        rf.register_op   = WRITE_REG_DATA;
        rf.wb_rd         = 5'd9;
        rf.register_data = 32'h99;
        #1;
        check("sat_pass", 32'(rf.issue_ready), 32'd1);
        step();
        do_issue(5'd9);
        #1;
        check("sat_still3", 32'(rf.issue_ready), 32'd0);
        step();

        // Simultaneous issue/commit on x4 keeps count at 1
        do_issue(5'd4);
        step();
        do_issue(5'd4);
        rf.register_op   = WRITE_REG_DATA;
        rf.wb_rd         = 5'd4;
        rf.register_data = 32'h44;
        step();
        set_idle();
        rf.rs1_addr = 5'd4;
        #1;
        check("p4_one", 32'(rf.hazard_stall), 32'd1);
        step();
        do_commit(5'd4, 32'h45);
        step();
        set_idle();
        rf.rs2_addr = 5'd4;
        #1;
        check("p4_zero", 32'(rf.hazard_stall), 32'd0);
        check("p4_data", rf.rs2_data, 32'h45);
        step();

        // Commit without prior issue: data lands, count clamps at 0
        do_commit(5'd12, 32'h1212_1212);
        step();
        set_idle();
        rf.rs1_addr = 5'd12;
        #1;
        check("p12_stall", 32'(rf.hazard_stall), 32'd0);
        check("p12_data", rf.rs1_data, 32'h1212_1212);
        step();
        do_issue(5'd12);
        step();
        set_idle();
        rf.rs1_addr = 5'd12;
        #1;
        check("p12_issued", 32'(rf.hazard_stall), 32'd1);
        step();

        // Random traffic on a narrow register window to force hazards
        for (int c = 0; c < 600; c++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r < 5)      rf.register_op = WRITE_REG_DATA;
            else if (r < 8) rf.register_op = NO_REG_DATA;
            else            rf.register_op = reg_file_op_t'(2'($urandom_range(2, 3)));
            rf.register_data = $urandom;
            rf.wb_rd         = 5'($urandom_range(0, 7));
            rf.rs1_addr      = 5'($urandom_range(0, 7));
            rf.rs2_addr      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
            rf.issue_valid   = 1'($urandom_range(0, 1));
            rf.issue_writes  = 1'($urandom_range(0, 1));
            rf.issue_rd      = 5'($urandom_range(0, 7));
            reset_n          = ($urandom_range(0, 63) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
